avl_rr_arbiter: RTL and testbench
=================================

Name: avl_rr_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single DDR3 UniPHY controller avl port (512-bit data, 24-bit word address, 3-bit burstcount).
- Two requesters can use the controller concurrently, e.g. the RW test engine plus a DMA/SFP datapath.
- Round-robin command arbitration, write-burst locking, and in-order read-response routing through a tag FIFO.
- Sits in the afi_clk domain between the masters and the controller.

Parameters:
- ADDR_W, 24, avl word address width
- DATA_W, 512, avl data width
- BE_W, 64, byte-enable width (DATA_W/8)
- SIZE_W, 3, burstcount width
- TAG_DEPTH, 16, max outstanding read commands (power of 2)

Ports:
- iCLK  in  1  afi_clk
- iRST  in  1  asynchronous, active-high reset
- local_init_done  in  1  controller calibrated/ready
- mN_read, mN_write, mN_burstbegin  in  1 each  master N command (N = 0, 1)
- mN_address  in  ADDR_W; mN_writedata  in  DATA_W; mN_be  in  BE_W; mN_size  in  SIZE_W
- mN_waitrequest_n  out  1; mN_readdatavalid  out  1; mN_readdata  out  DATA_W
- avl_ready  in  1; avl_rdata_valid  in  1; avl_rdata  in  DATA_W
- avl_read_req, avl_write_req, avl_burstbegin  out  1; avl_addr  out  ADDR_W; avl_wdata  out  DATA_W; avl_be  out  BE_W; avl_size  out  SIZE_W
- grant  out  1  master currently owning the command path
- rd_outstanding  out  $clog2(TAG_DEPTH)+1  queued read commands
- err_orphan  out  1  sticky: rdata_valid received with no tag queued

Behaviour:
- Reset values: all avl_* command outputs 0, all mN_waitrequest_n 0, all mN_readdatavalid 0, grant 0, rr_last 1 (m0 wins the first tie), lock 0, hold 0, tag FIFO empty, rd_outstanding 0, err_orphan 0.
- local_init_done=0: no command forwarded; both mN_waitrequest_n forced 0.
- Request: reqN = mN_read | mN_write. Accept = avl command asserted & avl_ready.
- Arbitration (combinational when lock=0 and hold=0):
  - Only one master requesting: select it.
  - Both requesting: select !rr_last.
  - Selected master is muxed straight onto avl_* with zero latency.
  - Non-selected master sees waitrequest_n=0.
  - grant reflects the selection.
- hold: set when a command is presented and avl_ready=0; grant is frozen until that accept. The controller never sees a stalled command change.
- rr_last updates to the selected master on every accept.
- Write burst lock (states UNLOCKED, WBURST):
  - First write beat accepted with size>1: enter WBURST, beat counter = size-1, grant frozen.
  - Each further accepted write beat decrements the counter; count reaching 0 returns to UNLOCKED.
  - In WBURST, only writes from the owner are forwarded. An owner read is stalled (waitrequest_n=0) until the burst ends.
  - size=0 is treated as 1.
- Reads are single-cycle commands.
  - On accept, push {master id, beats=size} into the tag FIFO.
  - FIFO full: selected read is not forwarded (avl_read_req=0, waitrequest_n=0). The other master's writes remain eligible under round robin.
- Response path:
  - avl_rdata is broadcast to both mN_readdata.
  - mN_readdatavalid = avl_rdata_valid & (head.id==N) & FIFO nonempty.
  - Head beat counter decrements per valid; the FIFO pops on the last beat.
  - Push and pop in the same cycle: count unchanged.
- Orphan: avl_rdata_valid with the FIFO empty sets err_orphan (sticky until reset); the data is dropped.
- Reset mid-operation: async clear of lock, hold, and FIFO. Responses still arriving from pre-reset reads are orphans.

Decomposition:
- Package avl_arb_pkg: constants ADDR_W/DATA_W/BE_W/SIZE_W defaults, master-id width, tag record {id, beats}.
- Sub-module avl_tag_fifo: synchronous FIFO, TAG_DEPTH entries; push/pop/full/empty/count/head; async active-high reset.

Test Plan:
- Only m0 issues a read at addr 0x000010, size 1, avl_ready=1 → avl_read_req high the same cycle; grant=0; rd_outstanding 0→1; one rdata_valid gives m0_readdatavalid=1, m1_readdatavalid=0; count returns to 0.
- m0 and m1 both request writes continuously → accepts alternate m0, m1, m0, m1; first grant goes to m0.
- m0 write burst size 4, m1 read arrives at beat 2 → m1 stalled until all 4 m0 beats accepted; m1 read issued next cycle.
- avl_ready=0 for 5 cycles with m1 presented, m0 asserts a request mid-stall → avl_addr/grant stable at m1 throughout; m1 accepted first.
- m0 issues 16 reads with no returns (TAG_DEPTH=16) → 17th read stalled with avl_read_req=0 and rd_outstanding=16; m1 write still accepted; one return unblocks it.
- Pulse iRST with 3 reads outstanding, then 3 rdata_valid → no mN_readdatavalid; err_orphan=1.

Source files
------------

// File: rtl/avl_arb_pkg.sv
// Shared widths, tag record and helpers for the two-master avl arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package avl_arb_pkg;

    localparam int AVL_ADDR_W    = 24;
    localparam int AVL_DATA_W    = 512;
    localparam int AVL_BE_W      = AVL_DATA_W / 8;
    localparam int AVL_SIZE_W    = 3;
    localparam int AVL_TAG_DEPTH = 16;
    localparam int MID_W         = 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        WBURST   = 1'b1
    } lock_state_t;

    typedef struct packed {
        logic [MID_W-1:0]      id;
        logic [AVL_SIZE_W-1:0] beats;
    } tag_t;

    // A burstcount of zero still moves one beat on the controller.
    function automatic logic [AVL_SIZE_W-1:0] eff_size(input logic [AVL_SIZE_W-1:0] size);
        return (size == '0) ? AVL_SIZE_W'(1) : size;
    endfunction

endpackage

// File: rtl/avl_tag_fifo.sv
// Generic synchronous FIFO used to queue read tags in command order.
// Latency: push visible at head one cycle later; head is a combinational read.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
module avl_tag_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/avl_rr_arbiter.sv
// Round-robin arbiter sharing one DDR3 avl port between two masters, with write-burst lock and tagged read return.
// Latency: commands pass combinationally (zero cycles); read data is broadcast with zero added cycles.
// Backpressure: avl_ready stalls via mN_waitrequest_n; a full tag FIFO stalls reads only.
module avl_rr_arbiter
    import avl_arb_pkg::*;
#(
    parameter int ADDR_W    = AVL_ADDR_W,
    parameter int DATA_W    = AVL_DATA_W,
    parameter int BE_W      = AVL_BE_W,
    parameter int SIZE_W    = AVL_SIZE_W,
    parameter int TAG_DEPTH = AVL_TAG_DEPTH
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       local_init_done,

    input  logic                       m0_read,
    input  logic                       m0_write,
    input  logic                       m0_burstbegin,
    input  logic [ADDR_W-1:0]          m0_address,
    input  logic [DATA_W-1:0]          m0_writedata,
    input  logic [BE_W-1:0]            m0_be,
    input  logic [SIZE_W-1:0]          m0_size,
    output logic                       m0_waitrequest_n,
    output logic                       m0_readdatavalid,
    output logic [DATA_W-1:0]          m0_readdata,

    input  logic                       m1_read,
    input  logic                       m1_write,
    input  logic                       m1_burstbegin,
    input  logic [ADDR_W-1:0]          m1_address,
    input  logic [DATA_W-1:0]          m1_writedata,
    input  logic [BE_W-1:0]            m1_be,
    input  logic [SIZE_W-1:0]          m1_size,
    output logic                       m1_waitrequest_n,
    output logic                       m1_readdatavalid,
    output logic [DATA_W-1:0]          m1_readdata,

    input  logic                       avl_ready,
    input  logic                       avl_rdata_valid,
    input  logic [DATA_W-1:0]          avl_rdata,
    output logic                       avl_read_req,
    output logic                       avl_write_req,
    output logic                       avl_burstbegin,
    output logic [ADDR_W-1:0]          avl_addr,
    output logic [DATA_W-1:0]          avl_wdata,
    output logic [BE_W-1:0]            avl_be,
    output logic [SIZE_W-1:0]          avl_size,

    output logic                       grant,
    output logic [$clog2(TAG_DEPTH):0] rd_outstanding,
    output logic                       err_orphan
);

    lock_state_t             lock_q;
    lock_state_t             lock_d;
    logic [AVL_SIZE_W-1:0]   burst_cnt;
    logic [AVL_SIZE_W-1:0]   burst_cnt_d;
    logic                    grant_q;
    logic                    hold_q;
    logic                    rr_last;

    logic [1:0]              m_wr;
    logic [1:0]              m_rd;
    logic [1:0]              elig;
    logic                    sel;
    logic                    cmd_vld;
    logic                    accept;
    logic [SIZE_W-1:0]       sel_size;
    logic [AVL_SIZE_W-1:0]   wr_size_eff;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    tag_push;
    logic                    tag_pop;
    tag_t                    push_tag;
    tag_t                    head_tag;
    logic [AVL_SIZE_W-1:0]   beat_cnt;
    logic                    rsp_vld;

    // A master is eligible only if its command could be accepted now:
    // during a write burst only the owner's writes, otherwise reads wait on tag space.
    always_comb begin
        m_wr = {m1_write, m0_write};
        m_rd = {m1_read & ~m1_write, m0_read & ~m0_write};
        if (lock_q == WBURST) begin
            elig = grant_q ? {m_wr[1], 1'b0} : {1'b0, m_wr[0]};
        end else begin
            elig = m_wr | (m_rd & {2{~fifo_full}});
        end
        if (!local_init_done) begin
            elig = 2'b00;
        end
    end

    always_comb begin
        sel = grant_q;
        if (lock_q == UNLOCKED && !hold_q) begin
            case (elig)
                2'b01:   sel = 1'b0;
                2'b10:   sel = 1'b1;
                2'b11:   sel = ~rr_last;
                default: sel = grant_q;
            endcase
        end
    end

    assign cmd_vld     = elig[sel];
    assign accept      = cmd_vld & avl_ready;
    assign sel_size    = sel ? m1_size : m0_size;
    assign wr_size_eff = eff_size(sel_size);
    assign grant       = sel;

    always_comb begin
        avl_read_req   = cmd_vld & ~m_wr[sel];
        avl_write_req  = cmd_vld & m_wr[sel];
        avl_burstbegin = '0;
        avl_addr       = '0;
        avl_wdata      = '0;
        avl_be         = '0;
        avl_size       = '0;
        if (cmd_vld) begin
            avl_burstbegin = sel ? m1_burstbegin : m0_burstbegin;
            avl_addr       = sel ? m1_address    : m0_address;
            avl_wdata      = sel ? m1_writedata  : m0_writedata;
            avl_be         = sel ? m1_be         : m0_be;
            avl_size       = sel_size;
        end
    end

    assign m0_waitrequest_n = accept & ~sel;
    assign m1_waitrequest_n = accept & sel;

    always_comb begin
        lock_d      = lock_q;
        burst_cnt_d = burst_cnt;
        case (lock_q)
            UNLOCKED: begin
                if (accept && avl_write_req && wr_size_eff > AVL_SIZE_W'(1)) begin
                    lock_d      = WBURST;
                    burst_cnt_d = wr_size_eff - AVL_SIZE_W'(1);
                end
            end
            WBURST: begin
                if (accept && avl_write_req) begin
                    burst_cnt_d = burst_cnt - AVL_SIZE_W'(1);
                    if (burst_cnt == AVL_SIZE_W'(1)) begin
                        lock_d = UNLOCKED;
                    end
                end
            end
            default: lock_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            lock_q    <= UNLOCKED;
            burst_cnt <= '0;
            grant_q   <= 1'b0;
            hold_q    <= 1'b0;
            rr_last   <= 1'b1;
        end else begin
            lock_q    <= lock_d;
            burst_cnt <= burst_cnt_d;
            grant_q   <= sel;
            hold_q    <= cmd_vld & ~avl_ready;
            if (accept) begin
                rr_last <= sel;
            end
        end
    end

    // Read tags: beats are stored raw and normalised when the response returns.
    assign tag_push       = accept & avl_read_req;
    assign push_tag.id    = sel;
    assign push_tag.beats = sel_size;

    avl_tag_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (iCLK),
        .rst      (iRST),
        .push     (tag_push),
        .push_dat (push_tag),
        .pop      (tag_pop),
        .head_dat (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (rd_outstanding)
    );

    assign rsp_vld          = avl_rdata_valid & ~fifo_empty;
    assign tag_pop          = rsp_vld & (beat_cnt == eff_size(head_tag.beats) - AVL_SIZE_W'(1));
    assign m0_readdatavalid = rsp_vld & (head_tag.id == 1'b0);
    assign m1_readdatavalid = rsp_vld & (head_tag.id == 1'b1);
    assign m0_readdata      = avl_rdata;
    assign m1_readdata      = avl_rdata;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            beat_cnt   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (tag_pop) begin
                beat_cnt <= '0;
            end else if (rsp_vld) begin
                beat_cnt <= beat_cnt + AVL_SIZE_W'(1);
            end
            if (avl_rdata_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avl_rr_arbiter.sv
// Self-checking bench for avl_rr_arbiter: directed command sequences plus a read-response scoreboard.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: avl_ready driven by the bench to exercise stalls.
module tb_avl_rr_arbiter;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 512;
    localparam int BE_W   = 64;
    localparam int SIZE_W = 3;
    localparam int CNT_W  = 5;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] dat;
    } rsp_t;

    logic              iCLK;
    logic              iRST;
    logic              local_init_done;
    logic              m0_read, m0_write, m0_burstbegin;
    logic [ADDR_W-1:0] m0_address;
    logic [DATA_W-1:0] m0_writedata;
    logic [BE_W-1:0]   m0_be;
    logic [SIZE_W-1:0] m0_size;
    logic              m0_waitrequest_n, m0_readdatavalid;
    logic [DATA_W-1:0] m0_readdata;
    logic              m1_read, m1_write, m1_burstbegin;
    logic [ADDR_W-1:0] m1_address;
    logic [DATA_W-1:0] m1_writedata;
    logic [BE_W-1:0]   m1_be;
    logic [SIZE_W-1:0] m1_size;
    logic              m1_waitrequest_n, m1_readdatavalid;
    logic [DATA_W-1:0] m1_readdata;
    logic              avl_ready, avl_rdata_valid;
    logic [DATA_W-1:0] avl_rdata;
    logic              avl_read_req, avl_write_req, avl_burstbegin;
    logic [ADDR_W-1:0] avl_addr;
    logic [DATA_W-1:0] avl_wdata;
    logic [BE_W-1:0]   avl_be;
    logic [SIZE_W-1:0] avl_size;
    logic              grant;
    logic [CNT_W-1:0]  rd_outstanding;
    logic              err_orphan;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic pend_q[$];
    rsp_t exp_q[$];

    avl_rr_arbiter dut (
        .iCLK(iCLK), .iRST(iRST), .local_init_done(local_init_done),
        .m0_read(m0_read), .m0_write(m0_write), .m0_burstbegin(m0_burstbegin),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_be(m0_be), .m0_size(m0_size),
        .m0_waitrequest_n(m0_waitrequest_n), .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
        .m1_read(m1_read), .m1_write(m1_write), .m1_burstbegin(m1_burstbegin),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_be(m1_be), .m1_size(m1_size),
        .m1_waitrequest_n(m1_waitrequest_n), .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
        .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
        .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_burstbegin(avl_burstbegin),
        .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be), .avl_size(avl_size),
        .grant(grant), .rd_outstanding(rd_outstanding), .err_orphan(err_orphan)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge iCLK);
    endtask

    task automatic idle_masters();
        m0_read = 0; m0_write = 0; m0_burstbegin = 0; m0_size = 3'd1;
        m1_read = 0; m1_write = 0; m1_burstbegin = 0; m1_size = 3'd1;
        avl_rdata_valid = 0;
    endtask

    task automatic do_reset();
        cyc();
        iRST = 1;
        idle_masters();
        avl_ready = 1;
        pend_q.delete();
        cyc();
        iRST = 0;
    endtask

    // Bench model of the tag FIFO: each returned beat is matched to the oldest issued read.
    task automatic respond(input logic [DATA_W-1:0] d);
        rsp_t e;
        avl_rdata_valid = 1;
        avl_rdata       = d;
        if (pend_q.size() != 0) begin
            e.id  = pend_q.pop_front();
            e.dat = d;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge iCLK) begin
        if (!iRST && (m0_readdatavalid || m1_readdatavalid)) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", {m1_readdatavalid, m0_readdatavalid}, 0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check_eq("rsp_id", {m1_readdatavalid, m0_readdatavalid}, e.id ? 2'b10 : 2'b01);
                check_eq("rsp_dat", e.id ? m1_readdata : m0_readdata, e.dat);
            end
        end
    end

    initial begin
        iRST = 1; local_init_done = 0; avl_ready = 0; avl_rdata = '0;
        m0_address = '0; m0_writedata = '0; m0_be = '1;
        m1_address = '0; m1_writedata = '0; m1_be = '1;
        idle_masters();
        smp();
        check_eq("rst_rd_req", avl_read_req, 0);
        check_eq("rst_wr_req", avl_write_req, 0);
        check_eq("rst_addr", avl_addr, 0);
        check_eq("rst_wrn", {m1_waitrequest_n, m0_waitrequest_n}, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_outst", rd_outstanding, 0);
        check_eq("rst_orphan", err_orphan, 0);

        // Uncalibrated controller: nothing forwarded.
        cyc(); iRST = 0; avl_ready = 1; m0_write = 1; m0_address = 24'h000123;
        smp();
        check_eq("noinit_wr_req", avl_write_req, 0);
        check_eq("noinit_wrn", m0_waitrequest_n, 0);
        cyc(); local_init_done = 1; idle_masters();

        // Single m0 read and its return.
        do_reset();
        m0_read = 1; m0_address = 24'h000010; m0_size = 3'd1;
        smp();
        check_eq("t1_rd_req", avl_read_req, 1);
        check_eq("t1_addr", avl_addr, 24'h000010);
        check_eq("t1_grant", grant, 0);
        check_eq("t1_wrn", m0_waitrequest_n, 1);
        check_eq("t1_outst0", rd_outstanding, 0);
        pend_q.push_back(1'b0);
        cyc(); m0_read = 0;
        smp();
        check_eq("t1_outst1", rd_outstanding, 1);
        cyc(); respond({8{64'hC0DE_0000_0000_0001}});
        smp();
        check_eq("t1_rdv0", m0_readdatavalid, 1);
        check_eq("t1_rdv1", m1_readdatavalid, 0);
        cyc(); avl_rdata_valid = 0;
        smp();
        check_eq("t1_outst_end", rd_outstanding, 0);
        check_eq("t1_missing", exp_q.size(), 0);

        // Both masters write continuously: strict alternation starting at m0.
        do_reset();
        m0_write = 1; m0_address = 24'h000100;
        m1_write = 1; m1_address = 24'h000200;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) cyc();
            smp();
            check_eq("t2_grant", grant, i % 2);
            check_eq("t2_wrn", {m1_waitrequest_n, m0_waitrequest_n}, (i % 2) ? 2'b10 : 2'b01);
            check_eq("t2_addr", avl_addr, (i % 2) ? 24'h000200 : 24'h000100);
        end

        // m0 write burst of 4 locks out an m1 read arriving at beat 2.
        do_reset();
        m0_write = 1; m0_size = 3'd4; m0_burstbegin = 1; m0_address = 24'h000040;
        for (int b = 1; b <= 4; b++) begin
            if (b != 1) cyc();
            if (b == 2) begin
                m0_burstbegin = 0;
                m1_read = 1; m1_address = 24'h000300; m1_size = 3'd1;
            end
            smp();
            check_eq("t3_beat_wrn0", m0_waitrequest_n, 1);
            check_eq("t3_beat_grant", grant, 0);
            check_eq("t3_m1_stall", m1_waitrequest_n, 0);
            check_eq("t3_no_rd", avl_read_req, 0);
        end
        cyc(); m0_size = 3'd1;
        smp();
        check_eq("t3_rd_req", avl_read_req, 1);
        check_eq("t3_grant", grant, 1);
        check_eq("t3_m1_wrn", m1_waitrequest_n, 1);
        check_eq("t3_addr", avl_addr, 24'h000300);
        pend_q.push_back(1'b1);
        cyc(); m1_read = 0;
        smp();
        check_eq("t3_m0_after", m0_waitrequest_n, 1);
        cyc(); m0_write = 0; respond({8{64'hBEEF_0000_0000_0003}});
        smp();
        check_eq("t3_rdv1", m1_readdatavalid, 1);
        cyc(); avl_rdata_valid = 0;
        smp();
        check_eq("t3_missing", exp_q.size(), 0);

        // Stalled m1 command stays frozen while m0 joins mid-stall.
        do_reset();
        avl_ready = 0; m1_write = 1; m1_address = 24'h000400;
        for (int c = 0; c < 5; c++) begin
            if (c != 0) cyc();
            if (c == 2) begin
                m0_write = 1; m0_address = 24'h000500;
            end
            smp();
            check_eq("t4_grant", grant, 1);
            check_eq("t4_addr", avl_addr, 24'h000400);
            check_eq("t4_wrn", {m1_waitrequest_n, m0_waitrequest_n}, 0);
        end
        cyc(); avl_ready = 1;
        smp();
        check_eq("t4_m1_acc", m1_waitrequest_n, 1);
        check_eq("t4_m0_wait", m0_waitrequest_n, 0);
        cyc(); m1_write = 0;
        smp();
        check_eq("t4_m0_acc", m0_waitrequest_n, 1);
        check_eq("t4_grant_m0", grant, 0);

        // Fill the tag FIFO with 16 m0 reads.
        do_reset();
        m0_read = 1; m0_size = 3'd1;
        for (int r = 0; r < 16; r++) begin
            if (r != 0) cyc();
            m0_address = 24'h001000 + ADDR_W'(r);
            smp();
            check_eq("t5_rd_acc", m0_waitrequest_n, 1);
            check_eq("t5_outst", rd_outstanding, r);
            pend_q.push_back(1'b0);
        end
        cyc(); m0_address = 24'h001010; m1_write = 1; m1_address = 24'h000600;
        smp();
        check_eq("t5_full_rd_req", avl_read_req, 0);
        check_eq("t5_full_wrn0", m0_waitrequest_n, 0);
        check_eq("t5_full_outst", rd_outstanding, 16);
        check_eq("t5_m1_wr_req", avl_write_req, 1);
        check_eq("t5_m1_wrn", m1_waitrequest_n, 1);
        check_eq("t5_m1_grant", grant, 1);
        cyc(); m1_write = 0; respond({8{64'hA5A5_0000_0000_0011}});
        smp();
        check_eq("t5_still_full", m0_waitrequest_n, 0);
        cyc(); avl_rdata_valid = 0;
        smp();
        check_eq("t5_unblk_wrn", m0_waitrequest_n, 1);
        check_eq("t5_unblk_rd", avl_read_req, 1);
        check_eq("t5_unblk_outst", rd_outstanding, 15);
        pend_q.push_back(1'b0);
        cyc(); m0_read = 0;
        smp();
        check_eq("t5_missing", exp_q.size(), 0);

        // Reset with reads in flight: late returns are orphans.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            if (r != 0) cyc();
            m0_read = (r % 2 == 0); m1_read = (r % 2 == 1);
            smp();
            check_eq("t6_issue", avl_read_req, 1);
            pend_q.push_back(r % 2 == 1);
        end
        cyc(); m0_read = 0; m1_read = 0;
        smp();
        check_eq("t6_outst3", rd_outstanding, 3);
        cyc(); iRST = 1; #2; iRST = 0; pend_q.delete();
        smp();
        check_eq("t6_outst_clr", rd_outstanding, 0);
        check_eq("t6_orphan_clr", err_orphan, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(); respond({8{64'hDEAD_0000_0000_0000}} + DATA_W'(k));
            smp();
            check_eq("t6_no_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
        end
        cyc(); avl_rdata_valid = 0;
        smp();
        check_eq("t6_orphan", err_orphan, 1);
        cyc();
        smp();
        check_eq("t6_orphan_sticky", err_orphan, 1);
        do_reset();
        smp();
        check_eq("t6_orphan_rst", err_orphan, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
